sram_arbiter: RTL and testbench

- Two-port arbiter and 32-bit sequencer in front of the external 16-bit SRAM request interface.
- Shares the SRAM between the instruction-fetch port (read-only) and the data port (read/write, 32- or 16-bit).
- Splits each 32-bit access into two halfword SRAM transactions and reassembles the read data.
- Sits between the core's fetch/LSU and the SRAM front-end; it is the only master of that front-end.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_rr_arb2.sv | 25 ++
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter/sequencer.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    StDrain,
    StIdle,
    StLoReq,
    StLoWait,
    StHiReq,
    StHiWait,
    StResp
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [31:0] SRAM_HW_STRIDE = 32'd2;

endpackage

// File: rtl/sram_rr_arb2.sv
// Combinational two-way round-robin picker: on contention the port that did not
// own the last grant wins.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant,
  output logic any_valid
);

  always_comb begin
    any_valid = i_req | d_req;
    grant     = last_grant;
    if (i_req && d_req) begin
      grant = ~last_grant;
    end else if (i_req) begin
      grant = GNT_I;
    end else if (d_req) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates fetch and data ports onto the 16-bit SRAM front-end and sequences
// 32-bit accesses as two halfword transactions, low halfword first.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned RESET_DRAIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic        d_rw,
  input  logic        d_half,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        sram_valid,
  output logic        sram_rw,
  output logic [31:0] sram_addr,
  output logic [15:0] sram_dtw,
  input  logic [15:0] sram_dtr,
  input  logic        sram_done,
  output logic        busy,
  output logic        grant
);

  localparam int unsigned CntW = $clog2(RESET_DRAIN + 2);

  state_e          state;
  logic [CntW-1:0] drain_cnt;
  logic            req_half;
  logic [15:0]     wdata_hi;
  logic [15:0]     data_lo;

  logic            pick_grant;
  logic            pick_any;
  logic [31:0]     acc_addr;
  logic            acc_rw;
  logic            acc_half;
  logic [31:0]     acc_wdata;
  logic [31:0]     rd_word;
  logic            unused_addr_bit;

  sram_rr_arb2 u_rr (
    .i_req     (i_valid),
    .d_req     (d_valid),
    .last_grant(grant),
    .grant     (pick_grant),
    .any_valid (pick_any)
  );

  // Request fields of whichever port the picker selects; fetches are always 32-bit reads.
  always_comb begin
    acc_addr  = i_addr;
    acc_rw    = 1'b0;
    acc_half  = 1'b0;
    acc_wdata = '0;
    if (pick_grant == GNT_D) begin
      acc_addr  = d_addr;
      acc_rw    = d_rw;
      acc_half  = d_half;
      acc_wdata = d_wdata;
    end
  end

  assign unused_addr_bit = acc_addr[0];

  assign rd_word = req_half ? {16'h0000, sram_dtr} : {sram_dtr, data_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StDrain;
      drain_cnt  <= CntW'(RESET_DRAIN);
      sram_valid <= 1'b0;
      sram_rw    <= 1'b0;
      sram_addr  <= '0;
      sram_dtw   <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
      grant      <= GNT_D;
      req_half   <= 1'b0;
      wdata_hi   <= '0;
      data_lo    <= '0;
    end else begin
      case (state)
        StDrain: begin
          if (drain_cnt == '0) begin
            state <= StIdle;
          end else begin
            drain_cnt <= drain_cnt - CntW'(1);
          end
        end
        StIdle: begin
          if (pick_any) begin
            grant      <= pick_grant;
            busy       <= 1'b1;
            sram_valid <= 1'b1;
            sram_rw    <= acc_rw;
            sram_dtw   <= acc_wdata[15:0];
            wdata_hi   <= acc_wdata[31:16];
            req_half   <= acc_half;
            if (acc_half) begin
              sram_addr <= {acc_addr[31:1], 1'b0};
              state     <= StHiReq;
            end else begin
              sram_addr <= {acc_addr[31:2], 2'b00};
              state     <= StLoReq;
            end
          end
        end
        StLoReq: begin
          sram_valid <= 1'b0;
          state      <= StLoWait;
        end
        StLoWait: begin
          if (sram_done) begin
            data_lo    <= sram_dtr;
            sram_addr  <= sram_addr + SRAM_HW_STRIDE;
            sram_dtw   <= wdata_hi;
            sram_valid <= 1'b1;
            state      <= StHiReq;
          end
        end
        StHiReq: begin
          sram_valid <= 1'b0;
          state      <= StHiWait;
        end
        StHiWait: begin
          // Ready and read data are registered here so they appear together in StResp.
          if (sram_done) begin
            state <= StResp;
            if (grant == GNT_I) begin
              i_ready <= 1'b1;
              i_rdata <= rd_word;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= rd_word;
            end
          end
        end
        StResp: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          busy    <= 1'b0;
          state   <= StIdle;
        end
        default: begin
          state <= StDrain;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM device model with fixed 4-cycle latency, table vectors,
// hand-written corner sequences and randomized requests against a halfword memory model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_valid = 1'b0;
  logic        d_rw = 1'b0;
  logic        d_half = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        sram_valid;
  logic        sram_rw;
  logic [31:0] sram_addr;
  logic [15:0] sram_dtw;
  logic [15:0] sram_dtr;
  logic        sram_done;
  logic        busy;
  logic        grant;

  sram_arbiter #(.RESET_DRAIN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_valid   (d_valid),
    .d_rw      (d_rw),
    .d_half    (d_half),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .sram_valid(sram_valid),
    .sram_rw   (sram_rw),
    .sram_addr (sram_addr),
    .sram_dtw  (sram_dtw),
    .sram_dtr  (sram_dtr),
    .sram_done (sram_done),
    .busy      (busy),
    .grant     (grant)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [15:0] dtw;
  } acc_t;

  typedef struct {
    bit          port;
    bit          rw;
    bit          half;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_a0;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          stray = 1'b0;
  acc_t        acc_q[$];
  logic [15:0] mem[logic [31:0]];
  logic [15:0] ref_mem[logic [31:0]];

  bit          pending = 1'b0;
  bit          done_now = 1'b0;
  int          due = 0;
  acc_t        cur;

  function automatic logic [15:0] dflt(input logic [31:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [15:0] dev_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // SRAM device: done exactly 4 cycles after each launch; also checks the launch protocol.
  initial begin
    sram_done = 1'b0;
    sram_dtr  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      sram_done = 1'b0;
      done_now  = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else if (pending && cyc == due) begin
        done_now  = 1'b1;
        sram_done = 1'b1;
        pending   = 1'b0;
        if (cur.rw) begin
          mem[cur.addr] = cur.dtw;
          sram_dtr = 16'h0000;
        end else begin
          sram_dtr = dev_rd(cur.addr);
        end
      end else if (stray) begin
        sram_done = 1'b1;
        sram_dtr  = 16'hFFFF;
        stray     = 1'b0;
      end
      @(negedge clk);
      if (done_now) begin
        chk("sram_stable_addr", sram_addr, cur.addr);
        chk("sram_stable_rw", {31'd0, sram_rw}, {31'd0, cur.rw});
        if (cur.rw) chk("sram_stable_dtw", {16'd0, sram_dtw}, {16'd0, cur.dtw});
      end
      if (sram_valid === 1'b1) begin
        chk("sram_overlap", {30'd0, pending, sram_done}, 32'd0);
        pending = 1'b1;
        due     = cyc + 4;
        cur     = '{sram_addr, sram_rw, sram_dtw};
        acc_q.push_back(cur);
      end
    end
  end

  // Issue one request at the current negedge (DUT must be idle) and check the whole transaction.
  task automatic do_req(input bit port, input bit rw_in, input bit half_in,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit drop,
                        input logic [31:0] exp_rd, input string name,
                        output logic [31:0] first_addr);
    acc_t        exp_acc[$];
    logic [31:0] base;
    logic [31:0] rd;
    logic [31:0] other_rd;
    bit          rw;
    bit          half;
    bit          got;
    int          lat;
    int          exp_lat;
    rw   = port ? rw_in : 1'b0;
    half = port ? half_in : 1'b0;
    if (half) begin
      base = {addr[31:1], 1'b0};
      exp_acc.push_back('{base, rw, wdata[15:0]});
      exp_lat = 6;
    end else begin
      base = {addr[31:2], 2'b00};
      exp_acc.push_back('{base, rw, wdata[15:0]});
      exp_acc.push_back('{base + 32'd2, rw, wdata[31:16]});
      exp_lat = 11;
    end
    other_rd = port ? i_rdata : d_rdata;
    acc_q.delete();
    if (port) begin
      d_valid = 1'b1; d_rw = rw; d_half = half; d_addr = addr; d_wdata = wdata;
    end else begin
      i_valid = 1'b1; i_addr = addr;
    end
    got = 1'b0;
    lat = 0;
    rd  = '0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({name, ":busy_on"}, {31'd0, busy}, 32'd1);
        chk({name, ":grant"}, {31'd0, grant}, {31'd0, port});
      end
      if (drop && k == 2) begin
        i_valid = 1'b0;
        d_valid = 1'b0;
      end
      chk({name, ":other_ready"}, {31'd0, port ? i_ready : d_ready}, 32'd0);
      if ((port ? d_ready : i_ready) === 1'b1) begin
        got = 1'b1;
        lat = k;
        rd  = port ? d_rdata : i_rdata;
        chk({name, ":busy_at_ready"}, {31'd0, busy}, 32'd1);
      end
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    chk({name, ":latency"}, lat, exp_lat);
    if (!rw) chk({name, ":rdata"}, rd, exp_rd);
    chk({name, ":other_rdata"}, port ? i_rdata : d_rdata, other_rd);
    chk({name, ":n_access"}, acc_q.size(), exp_acc.size());
    for (int j = 0; j < exp_acc.size() && j < acc_q.size(); j++) begin
      chk({name, ":acc_addr"}, acc_q[j].addr, exp_acc[j].addr);
      chk({name, ":acc_rw"}, {31'd0, acc_q[j].rw}, {31'd0, exp_acc[j].rw});
      if (rw) chk({name, ":acc_dtw"}, {16'd0, acc_q[j].dtw}, {16'd0, exp_acc[j].dtw});
    end
    first_addr = (acc_q.size() > 0) ? acc_q[0].addr : 32'hFFFF_FFFF;
    @(negedge clk);
    chk({name, ":ready_drop"}, {30'd0, i_ready, d_ready}, 32'd0);
    chk({name, ":busy_gap"}, {31'd0, busy}, 32'd0);
    if (rw) foreach (exp_acc[j]) ref_mem[exp_acc[j].addr] = exp_acc[j].dtw;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        tbl[9];
  logic [31:0] fa;
  logic [31:0] ir;
  logic [31:0] dr;
  logic        g;
  int          seq[4];
  int          nrdy;
  int          since;
  bit          got5;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 32'h1000};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_2003, 32'h1234_5678, 32'h0,          32'h2000};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_3002, 32'h0,          32'h0000_A5A5, 32'h3002};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0,          32'h1234_5678, 32'h2000};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_2003, 32'h0,          32'h0000_1234, 32'h2002};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_4007, 32'hFFFF_CAFE, 32'h0,          32'h4006};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_4006, 32'h0,          32'hCAFE_1111, 32'h4004};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_4004, 32'h0000_2222, 32'h0,          32'h4004};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h0000_4005, 32'h0,          32'hCAFE_2222, 32'h4004};

    mem[32'h1000] = 16'hBEEF; ref_mem[32'h1000] = 16'hBEEF;
    mem[32'h1002] = 16'hDEAD; ref_mem[32'h1002] = 16'hDEAD;
    mem[32'h3002] = 16'hA5A5; ref_mem[32'h3002] = 16'hA5A5;
    mem[32'h4004] = 16'h1111; ref_mem[32'h4004] = 16'h1111;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_sram_valid", {31'd0, sram_valid}, 32'd0);
    chk("rst_sram_rw", {31'd0, sram_rw}, 32'd0);
    chk("rst_sram_addr", sram_addr, 32'd0);
    chk("rst_sram_dtw", {16'd0, sram_dtw}, 32'd0);
    chk("rst_readys", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd1);
    rst = 1'b0;

    // Contention straight out of reset: fetch wins first, then strict alternation.
    i_valid = 1'b1; i_addr = 32'h1000;
    d_valid = 1'b1; d_rw = 1'b0; d_half = 1'b1; d_addr = 32'h3002; d_wdata = '0;
    foreach (seq[j]) seq[j] = -1;
    nrdy  = 0;
    since = -1;
    for (int k = 0; k < 200 && nrdy < 4; k++) begin
      @(negedge clk);
      if (since >= 0) since++;
      if (since == 1) chk("contend_busy_low", {31'd0, busy}, 32'd0);
      if (since == 2) begin
        chk("contend_busy_high", {31'd0, busy}, 32'd1);
        since = -1;
      end
      if (i_ready === 1'b1 || d_ready === 1'b1) begin
        chk("contend_one_ready", {30'd0, i_ready, d_ready} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
        seq[nrdy] = d_ready ? 1 : 0;
        chk("contend_grant", {31'd0, grant}, d_ready ? 32'd1 : 32'd0);
        if (d_ready) chk("contend_d_rdata", d_rdata, 32'h0000_A5A5);
        else chk("contend_i_rdata", i_rdata, 32'hDEAD_BEEF);
        nrdy++;
        since = 0;
      end
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    chk("contend_count", nrdy, 32'd4);
    for (int j = 0; j < 4; j++) chk("contend_order", seq[j], j % 2);
    @(negedge clk);
    chk("contend_idle", {31'd0, busy}, 32'd0);

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      do_req(tbl[v].port, tbl[v].rw, tbl[v].half, tbl[v].addr, tbl[v].wdata, 1'b0,
             tbl[v].exp_rd, $sformatf("vec%0d", v), fa);
      chk($sformatf("vec%0d:first_addr", v), fa, tbl[v].exp_a0);
    end

    // Reset while waiting on the low halfword, stray done during drain.
    i_valid = 1'b1; i_addr = 32'h1000;
    @(negedge clk);
    chk("t5_launch", {31'd0, sram_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    stray = 1'b1;
    chk("t5_rst_valid", {31'd0, sram_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_grant", {31'd0, grant}, 32'd1);
    chk("t5_rst_ready", {31'd0, i_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_drain_quiet", {30'd0, sram_valid, i_ready}, 32'd0);
    end
    got5 = 1'b0;
    for (int k = 0; k < 40 && !got5; k++) begin
      @(negedge clk);
      if (i_ready === 1'b1) begin
        got5 = 1'b1;
        chk("t5_rdata", i_rdata, 32'hDEAD_BEEF);
      end
    end
    i_valid = 1'b0;
    chk("t5_completed", {31'd0, got5}, 32'd1);
    @(negedge clk);
    chk("t5_after", {30'd0, i_ready, busy}, 32'd0);

    // Requester drops valid early; then a spurious done while idle.
    do_req(1'b0, 1'b0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'hDEAD_BEEF, "t6_drop", fa);
    ir = i_rdata;
    dr = d_rdata;
    g  = grant;
    stray = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_i_rdata", i_rdata, ir);
      chk("t6_d_rdata", d_rdata, dr);
      chk("t6_grant", {31'd0, grant}, {31'd0, g});
      chk("t6_quiet", {28'd0, busy, i_ready, d_ready, sram_valid}, 32'd0);
    end
    do_req(1'b1, 1'b0, 1'b1, 32'h3002, 32'h0, 1'b0, 32'h0000_A5A5, "t6_after", fa);

    // Randomized requests against the halfword memory model.
    for (int n = 0; n < 40; n++) begin
      bit          port;
      bit          rw;
      bit          half;
      bit          drop;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] b;
      logic [31:0] exp;
      port  = 1'($urandom_range(0, 1));
      rw    = port ? 1'($urandom_range(0, 1)) : 1'b0;
      half  = port ? 1'($urandom_range(0, 1)) : 1'b0;
      drop  = ($urandom_range(0, 7) == 0);
      addr  = 32'h5000 | ($urandom & 32'h1F);
      wdata = $urandom;
      if (half) begin
        b   = addr & ~32'd1;
        exp = {16'h0000, ref_rd(b)};
      end else begin
        b   = addr & ~32'd3;
        exp = {ref_rd(b + 32'd2), ref_rd(b)};
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(port, rw, half, addr, wdata, drop, exp, $sformatf("rnd%0d", n), fa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
